// File: rtl/bcd_dabble_converter.sv
`timescale 1ns/1ps
// bcd_dabble_converter
//   Sequential binary-to-BCD converter using the shift-and-add-3
//   ("double dabble") algorithm, one bit per clock.
//
//   Handshake (both sides): a transfer happens on a rising edge where
//   valid && ready are both high. The producer holds valid/data until that
//   edge. The consumer may hold ready low for any number of cycles, during
//   which the result stays stable.
//
// Parameters
//   WIDTH   binary operand width (1..32)
//   DIGITS  number of BCD output digits (1..9)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   bin holds an operand to convert
//   in_ready   converter can accept an operand this cycle (IDLE and not in reset)
//   bin        unsigned binary operand
//   out_valid  bcd/blank/ovf hold a completed result
//   out_ready  consumer takes the result this cycle
//   bcd        packed BCD, digit i in bits [4i+3:4i], digit 0 = ones
//   blank      per-digit leading-zero suppression flags (blank[0] always 0)
//   ovf        operand exceeded 10^DIGITS-1 (bcd saturated to all nines)
//   busy       conversion in progress (SHIFT state)
//   state_o    current FSM state, for observation (0=IDLE, 1=SHIFT, 2=DONE)
module bcd_dabble_converter #(
    parameter int WIDTH  = 5,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  ovf,
    output logic                  busy,
    output logic [1:0]            state_o
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    localparam logic [63:0]       MAX_VAL   = pow10(DIGITS) - 64'd1;
    // Reset pattern: every digit but the ones digit blanked.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [SW-1:0]       sr_q;
    logic [SW-1:0]       sr_d;
    logic [CW-1:0]       cnt_q;
    logic                ovf_in_q;
    logic                ovf_q;
    logic                out_valid_q;
    logic [BW-1:0]       bcd_q;
    logic [DIGITS-1:0]   blank_q;
    logic [BW-1:0]       digits_d;
    logic [DIGITS-1:0]   blank_d;
    logic                zero_above;

    // One dabble step: correct nibbles >= 5 so the shift carries into the
    // next decade, then shift the whole {bcd, binary} register left.
    always_comb begin
        sr_d = sr_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr_q[WIDTH + 4*d +: 4] >= 4'd5) begin
                sr_d[WIDTH + 4*d +: 4] = sr_q[WIDTH + 4*d +: 4] + 4'd3;
            end
        end
        sr_d = sr_d << 1;
        digits_d = sr_d[SW-1:WIDTH];

        // Leading-zero flags from the final digits, scanned from the top
        // down; the ones digit is never blanked.
        blank_d    = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (digits_d[4*i +: 4] == 4'd0);
            blank_d[i] = zero_above;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            ovf_in_q    <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            blank_q     <= BLANK_RST;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sr_q     <= {BW'(0), bin};
                        cnt_q    <= CW'(WIDTH);
                        ovf_in_q <= (64'(bin) > MAX_VAL);
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q - CW'(1);
                    // Last iteration: publish the shifted value directly so
                    // the result is valid WIDTH cycles after acceptance.
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        ovf_q       <= ovf_in_q;
                        if (ovf_in_q) begin
                            bcd_q   <= {DIGITS{4'h9}};
                            blank_q <= '0;
                        end else begin
                            bcd_q   <= digits_d;
                            blank_q <= blank_d;
                        end
                    end
                end
                DONE: begin
                    // Returning to IDLE leaves a one-cycle bubble before
                    // the next operand can be accepted.
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign busy      = (state_q == SHIFT);
    assign out_valid = out_valid_q;
    assign bcd       = bcd_q;
    assign blank     = blank_q;
    assign ovf       = ovf_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_bcd_dabble_converter.sv
`timescale 1ns/1ps
module tb_bcd_dabble_converter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- instance A: defaults (WIDTH=5, DIGITS=2) ----------------
    logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b1;
    logic        ovf_a, busy_a;
    logic [4:0]  bin_a = '0;
    logic [7:0]  bcd_a;
    logic [1:0]  blank_a, state_a;

    bcd_dabble_converter u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .bin(bin_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .bcd(bcd_a), .blank(blank_a), .ovf(ovf_a), .busy(busy_a), .state_o(state_a)
    );

    // ---------------- instance B: WIDTH=8, DIGITS=2 ----------------
    logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1;
    logic        ovf_b, busy_b;
    logic [7:0]  bin_b = '0;
    logic [7:0]  bcd_b;
    logic [1:0]  blank_b, state_b;

    bcd_dabble_converter #(.WIDTH(8), .DIGITS(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .bin(bin_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .bcd(bcd_b), .blank(blank_b), .ovf(ovf_b), .busy(busy_b), .state_o(state_b)
    );

    // ---------------- instance C: WIDTH=16, DIGITS=5 ----------------
    logic        in_valid_c = 1'b0, in_ready_c, out_valid_c, out_ready_c = 1'b1;
    logic        ovf_c, busy_c;
    logic [15:0] bin_c = '0;
    logic [19:0] bcd_c;
    logic [4:0]  blank_c;
    logic [1:0]  state_c;

    bcd_dabble_converter #(.WIDTH(16), .DIGITS(5)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .bin(bin_c), .out_valid(out_valid_c), .out_ready(out_ready_c),
        .bcd(bcd_c), .blank(blank_c), .ovf(ovf_c), .busy(busy_c), .state_o(state_c)
    );

    // ---------------- scoreboard queues: {ovf, blank, bcd} ----------------
    logic [10:0] exp_a_q[$];
    logic [10:0] exp_b_q[$];
    logic [25:0] exp_c_q[$];
    int spur_a = 0, spur_b = 0, spur_c = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model by repeated division; packed {ovf, blank, bcd}.
    function automatic logic [63:0] model(input longint unsigned v, input int digits);
        logic [63:0] r;
        longint unsigned p, t;
        r = '0;
        p = 1;
        for (int k = 0; k < digits; k++) p = p * 10;
        if (v >= p) begin
            for (int k = 0; k < digits; k++) r[4*k +: 4] = 4'h9;
            r[5*digits] = 1'b1;
        end else begin
            t = v;
            for (int k = 0; k < digits; k++) begin
                r[4*k +: 4] = 4'(t % 10);
                t = t / 10;
            end
            p = 10;
            for (int i = 1; i < digits; i++) begin
                r[4*digits + i] = (v < p);
                p = p * 10;
            end
        end
        return r;
    endfunction

    // ---------------- output monitors (sample on falling edge) ----------------
    always @(negedge clk) begin
        if (out_valid_a && out_ready_a) begin
            if (exp_a_q.size() == 0) spur_a++;
            else begin
                check("a_result", 64'({ovf_a, blank_a, bcd_a}), 64'(exp_a_q.pop_front()));
                for (int i = 0; i < 2; i++) check("a_nibble_le9", 64'(bcd_a[4*i +: 4] <= 4'd9), 64'd1);
            end
        end
        if (out_valid_b && out_ready_b) begin
            if (exp_b_q.size() == 0) spur_b++;
            else check("b_result", 64'({ovf_b, blank_b, bcd_b}), 64'(exp_b_q.pop_front()));
        end
        if (out_valid_c && out_ready_c) begin
            if (exp_c_q.size() == 0) spur_c++;
            else check("c_result", 64'({ovf_c, blank_c, bcd_c}), 64'(exp_c_q.pop_front()));
        end
    end

    // ---------------- driver tasks (drive at posedge + 1) ----------------
    task automatic send_a(input logic [4:0] v, input logic [10:0] e);
        int t = 0;
        while (!in_ready_a && t < 100) begin @(posedge clk); #1; t++; end
        if (!in_ready_a) begin check("a_send_timeout", 64'(in_ready_a), 64'd1); return; end
        in_valid_a = 1'b1; bin_a = v;
        exp_a_q.push_back(e);
        @(posedge clk); #1;
        in_valid_a = 1'b0; bin_a = 5'($urandom);
    endtask

    task automatic send_b(input logic [7:0] v, input logic [10:0] e);
        int t = 0;
        while (!in_ready_b && t < 100) begin @(posedge clk); #1; t++; end
        if (!in_ready_b) begin check("b_send_timeout", 64'(in_ready_b), 64'd1); return; end
        in_valid_b = 1'b1; bin_b = v;
        exp_b_q.push_back(e);
        @(posedge clk); #1;
        in_valid_b = 1'b0; bin_b = 8'($urandom);
    endtask

    task automatic send_c(input logic [15:0] v, input logic [25:0] e);
        int t = 0;
        while (!in_ready_c && t < 100) begin @(posedge clk); #1; t++; end
        if (!in_ready_c) begin check("c_send_timeout", 64'(in_ready_c), 64'd1); return; end
        in_valid_c = 1'b1; bin_c = v;
        exp_c_q.push_back(e);
        @(posedge clk); #1;
        in_valid_c = 1'b0; bin_c = 16'($urandom);
    endtask

    task automatic drain_a(input bit rnd);
        int t = 0;
        while (exp_a_q.size() != 0 && t < 300) begin
            @(posedge clk); #1;
            if (rnd) out_ready_a = 1'($urandom_range(0, 1));
            t++;
        end
        out_ready_a = 1'b1;
        if (exp_a_q.size() != 0) begin
            check("a_drain_timeout", 64'(exp_a_q.size()), 64'd0);
            exp_a_q.delete();
        end
    endtask

    task automatic drain_b();
        int t = 0;
        while (exp_b_q.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
        if (exp_b_q.size() != 0) begin
            check("b_drain_timeout", 64'(exp_b_q.size()), 64'd0);
            exp_b_q.delete();
        end
    endtask

    task automatic drain_c();
        int t = 0;
        while (exp_c_q.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
        if (exp_c_q.size() != 0) begin
            check("c_drain_timeout", 64'(exp_c_q.size()), 64'd0);
            exp_c_q.delete();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        int v;

        // Reset state, sampled while rst is still high.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_low", 64'(in_ready_a), 64'd0);
        check("rst_out_valid",    64'(out_valid_a), 64'd0);
        check("rst_bcd",          64'(bcd_a), 64'd0);
        check("rst_blank",        64'(blank_a), 64'b10);
        check("rst_ovf",          64'(ovf_a), 64'd0);
        check("rst_busy",         64'(busy_a), 64'd0);
        check("rst_state",        64'(state_a), 64'd0);
        check("rst_blank_c",      64'(blank_c), 64'b11110);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready_a), 64'd1);

        // bin=31: latency 5, result 31.
        send_a(5'd31, {1'b0, 2'b00, 8'h31});
        check("a_busy_shift",     64'(busy_a), 64'd1);
        check("a_in_ready_shift", 64'(in_ready_a), 64'd0);
        lat = 0;
        while (!out_valid_a && lat < 100) begin @(posedge clk); #1; lat++; end
        check("a_latency", 64'(lat), 64'd5);
        drain_a(0);

        // bin=0 then bin=7.
        send_a(5'd0, {1'b0, 2'b10, 8'h00});
        drain_a(0);
        send_a(5'd7, {1'b0, 2'b10, 8'h07});
        drain_a(0);

        // Back-pressure with in_valid held high and bin=9.
        out_ready_a = 1'b0;
        in_valid_a  = 1'b1;
        bin_a       = 5'd9;
        exp_a_q.push_back({1'b0, 2'b10, 8'h09});
        lat = 0;
        while (!out_valid_a && lat < 100) begin @(posedge clk); #1; lat++; end
        check("bp_out_valid", 64'(out_valid_a), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_result", 64'({ovf_a, blank_a, bcd_a}), 64'({1'b0, 2'b10, 8'h09}));
            check("bp_hold_valid",  64'(out_valid_a), 64'd1);
            check("bp_in_ready",    64'(in_ready_a), 64'd0);
            @(posedge clk); #1;
        end
        exp_a_q.push_back({1'b0, 2'b10, 8'h09});
        out_ready_a = 1'b1;
        @(posedge clk); #1;
        check("bp_bubble_valid", 64'(out_valid_a), 64'd0);
        check("bp_bubble_ready", 64'(in_ready_a), 64'd1);
        @(posedge clk); #1;
        check("bp_reaccept_busy", 64'(busy_a), 64'd1);
        in_valid_a = 1'b0;
        drain_a(0);

        // Random operands with random consumer back-pressure.
        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(0, 31);
            send_a(5'(v), 11'(model(longint'(v), 2)));
            drain_a(1);
        end

        // WIDTH=8, DIGITS=2: overflow boundary.
        send_b(8'd200, {1'b1, 2'b00, 8'h99});
        send_b(8'd99,  {1'b0, 2'b00, 8'h99});
        send_b(8'd100, {1'b1, 2'b00, 8'h99});
        send_b(8'd255, {1'b1, 2'b00, 8'h99});
        send_b(8'd0,   {1'b0, 2'b10, 8'h00});
        send_b(8'd10,  {1'b0, 2'b00, 8'h10});
        for (int i = 0; i < 10; i++) begin
            v = $urandom_range(0, 255);
            send_b(8'(v), 11'(model(longint'(v), 2)));
        end
        drain_b();

        // WIDTH=16, DIGITS=5: full range, latency 16, leading zeros.
        send_c(16'd65535, {1'b0, 5'b00000, 20'h65535});
        lat = 0;
        while (!out_valid_c && lat < 100) begin @(posedge clk); #1; lat++; end
        check("c_latency", 64'(lat), 64'd16);
        drain_c();
        send_c(16'd40,   {1'b0, 5'b11100, 20'h00040});
        send_c(16'd0,    {1'b0, 5'b11110, 20'h00000});
        send_c(16'd9999, {1'b0, 5'b10000, 20'h09999});
        for (int i = 0; i < 10; i++) begin
            v = $urandom_range(0, 65535);
            send_c(16'(v), 26'(model(longint'(v), 5)));
        end
        drain_c();

        // Reset on the 3rd SHIFT cycle of bin=31 aborts the conversion.
        in_valid_a = 1'b1;
        bin_a      = 5'd31;
        @(posedge clk); #1;
        in_valid_a = 1'b0;
        check("abort_busy", 64'(busy_a), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_in_ready_in_rst", 64'(in_ready_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_state",     64'(state_a), 64'd0);
        check("abort_out_valid", 64'(out_valid_a), 64'd0);
        check("abort_bcd",       64'(bcd_a), 64'd0);
        check("abort_blank",     64'(blank_a), 64'b10);
        check("abort_ovf",       64'(ovf_a), 64'd0);
        check("abort_busy_low",  64'(busy_a), 64'd0);
        check("abort_in_ready",  64'(in_ready_a), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_result", 64'(out_valid_a), 64'd0);
        send_a(5'd12, {1'b0, 2'b00, 8'h12});
        drain_a(0);

        repeat (3) @(posedge clk);
        check("spurious_a", 64'(spur_a), 64'd0);
        check("spurious_b", 64'(spur_b), 64'd0);
        check("spurious_c", 64'(spur_c), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
